// File: rtl/immediate_unit_pkg.sv
// Shared immediate-format select codes and widths for the immediate unit.
// IMM_TARGET_EN (optional) adds PC-relative target output; see immediate_unit.sv.
package immediate_unit_pkg;
    localparam int IMM_SEL_W = 3;

    // Codes 6 and 7 are undefined and flagged as illegal.
    typedef enum logic [IMM_SEL_W-1:0] {
        IMM_ITYPE = 3'd0,
        IMM_STYPE = 3'd1,
        IMM_BTYPE = 3'd2,
        IMM_UTYPE = 3'd3,
        IMM_JTYPE = 3'd4,
        IMM_ZTYPE = 3'd5
    } imm_sel_e;
endpackage

// File: rtl/immediate_unit_if.sv
// Decode-side and execute-side handshake bundle of the immediate unit.
// IMM_TARGET_EN adds I_pc / O_target to the bundle.
interface immediate_unit_if #(
    parameter int XLEN   = 32,
    parameter int INST_W = 32
);
    import immediate_unit_pkg::*;

    logic                 I_flush;
    logic                 I_valid;
    logic                 O_ready;
    logic [IMM_SEL_W-1:0] I_immsel;
    logic [INST_W-1:0]    I_data;
    logic                 O_valid;
    logic                 I_ready;
    logic [XLEN-1:0]      O_data;
    logic                 O_illegal;
`ifdef IMM_TARGET_EN
    logic [XLEN-1:0]      I_pc;
    logic [XLEN-1:0]      O_target;

    modport slave  (input  I_flush, I_valid, I_immsel, I_data, I_ready, I_pc,
                    output O_ready, O_valid, O_data, O_illegal, O_target);
    modport master (output I_flush, I_valid, I_immsel, I_data, I_ready, I_pc,
                    input  O_ready, O_valid, O_data, O_illegal, O_target);
`else
    modport slave  (input  I_flush, I_valid, I_immsel, I_data, I_ready,
                    output O_ready, O_valid, O_data, O_illegal);
    modport master (output I_flush, I_valid, I_immsel, I_data, I_ready,
                    input  O_ready, O_valid, O_data, O_illegal);
`endif
endinterface

// File: rtl/imm_extract.sv
// Combinational RISC-V immediate extraction, sign-extended (zimm zero-extended) to XLEN.
module imm_extract
    import immediate_unit_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int INST_W = 32
) (
    input  logic [IMM_SEL_W-1:0] immsel_i,
    input  logic [INST_W-1:0]    inst_i,
    output logic [XLEN-1:0]      imm_o,
    output logic                 illegal_o
);
    logic signed [31:0] imm32;
    logic               unused_opcode;

    assign unused_opcode = ^inst_i[6:0];

    always_comb begin
        imm32     = '0;
        illegal_o = 1'b0;
        case (immsel_i)
            IMM_ITYPE: imm32 = {{20{inst_i[31]}}, inst_i[31:20]};
            IMM_STYPE: imm32 = {{20{inst_i[31]}}, inst_i[31:25], inst_i[11:7]};
            IMM_BTYPE: imm32 = {{19{inst_i[31]}}, inst_i[31], inst_i[7], inst_i[30:25],
                                inst_i[11:8], 1'b0};
            IMM_UTYPE: imm32 = {inst_i[31:12], 12'b0};
            IMM_JTYPE: imm32 = {{11{inst_i[31]}}, inst_i[31], inst_i[19:12], inst_i[20],
                                inst_i[30:21], 1'b0};
            IMM_ZTYPE: imm32 = {27'b0, inst_i[19:15]};
            default:   illegal_o = 1'b1;
        endcase
    end

    // Signed cast widens with inst[31] for RV64; zimm is non-negative so it zero-extends.
    assign imm_o = XLEN'(imm32);
endmodule

// File: rtl/immediate_unit.sv
// Pipelined immediate unit: one output register plus a 1-entry skid buffer, valid/ready both sides.
// IMM_TARGET_EN: carry the PC with each entry and register O_target = pc + imm alongside O_data.
module immediate_unit
    import immediate_unit_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int INST_W = 32
) (
    input logic              I_clk,
    input logic              I_rst_n,
    immediate_unit_if.slave  bus
);
    if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
        $error("immediate_unit: XLEN must be 32 or 64");
    end

    typedef struct packed {
        logic [XLEN-1:0] imm;
        logic            illegal;
`ifdef IMM_TARGET_EN
        logic [XLEN-1:0] target;
`endif
    } entry_t;

    logic [XLEN-1:0] ext_imm;
    logic            ext_ill;
    entry_t          in_e;
    entry_t          main_q, main_d, skid_q, skid_d;
    logic            main_vld_q, main_vld_d, skid_vld_q, skid_vld_d;
    logic            acc, xfer;

    imm_extract #(.XLEN(XLEN), .INST_W(INST_W)) u_extract (
        .immsel_i  (bus.I_immsel),
        .inst_i    (bus.I_data),
        .imm_o     (ext_imm),
        .illegal_o (ext_ill)
    );

    always_comb begin
        in_e         = '0;
        in_e.imm     = ext_imm;
        in_e.illegal = ext_ill;
`ifdef IMM_TARGET_EN
        in_e.target  = bus.I_pc + ext_imm;
`endif
    end

    assign acc  = bus.I_valid & ~skid_vld_q;
    assign xfer = main_vld_q & bus.I_ready;

    always_comb begin
        main_d     = main_q;
        skid_d     = skid_q;
        main_vld_d = main_vld_q;
        skid_vld_d = skid_vld_q;
        if (bus.I_flush) begin
            main_vld_d = 1'b0;
            skid_vld_d = 1'b0;
        end else if (skid_vld_q) begin
            if (xfer) begin
                main_d     = skid_q;
                skid_vld_d = 1'b0;
            end
        end else if (acc && (!main_vld_q || xfer)) begin
            // Empty, or draining this edge: the new entry lands in main with no bubble.
            main_d     = in_e;
            main_vld_d = 1'b1;
        end else if (acc) begin
            skid_d     = in_e;
            skid_vld_d = 1'b1;
        end else if (xfer) begin
            main_vld_d = 1'b0;
        end
    end

    always_ff @(posedge I_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            main_q     <= '0;
            skid_q     <= '0;
            main_vld_q <= 1'b0;
            skid_vld_q <= 1'b0;
        end else begin
            main_q     <= main_d;
            skid_q     <= skid_d;
            main_vld_q <= main_vld_d;
            skid_vld_q <= skid_vld_d;
        end
    end

    assign bus.O_valid   = main_vld_q;
    assign bus.O_data    = main_q.imm;
    assign bus.O_illegal = main_q.illegal;
    assign bus.O_ready   = ~skid_vld_q;
`ifdef IMM_TARGET_EN
    assign bus.O_target  = main_q.target;
`endif
endmodule

// File: tb/tb_immediate_unit.sv
// Self-checking bench for immediate_unit: directed format cases, backpressure, flush, reset,
// and a random stream against a queue-based reference model (XLEN=32 and XLEN=64 instances).
module tb_immediate_unit;
    import immediate_unit_pkg::*;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    immediate_unit_if #(.XLEN(32)) bus ();
    immediate_unit_if #(.XLEN(64)) bus64 ();

    immediate_unit #(.XLEN(32)) u_dut   (.I_clk(clk), .I_rst_n(rst_n), .bus(bus.slave));
    immediate_unit #(.XLEN(64)) u_dut64 (.I_clk(clk), .I_rst_n(rst_n), .bus(bus64.slave));

    int n_cmp  = 0;
    int n_fail = 0;

    typedef struct {
        logic [63:0] imm;
        bit          ill;
        logic [63:0] tgt;
    } exp_t;

    exp_t sb[$];

    // Immediate value assembled from field weights, then two's-complement folded at its sign bit.
    function automatic exp_t ref_model(input int sel, input logic [31:0] i,
                                       input logic [63:0] pc, input int xlen);
        exp_t   e;
        longint v;
        int     w;
        e.ill = 0;
        v     = 0;
        w     = 0;
        case (sel)
            int'(IMM_ITYPE): begin v = longint'(i[31:20]); w = 12; end
            int'(IMM_STYPE): begin v = longint'(i[31:25]) * 32 + longint'(i[11:7]); w = 12; end
            int'(IMM_BTYPE): begin
                v = longint'(i[31]) * 4096 + longint'(i[7]) * 2048 +
                    longint'(i[30:25]) * 32 + longint'(i[11:8]) * 2;
                w = 13;
            end
            int'(IMM_UTYPE): begin v = longint'(i[31:12]) * 4096; w = 32; end
            int'(IMM_JTYPE): begin
                v = longint'(i[31]) * 1048576 + longint'(i[19:12]) * 4096 +
                    longint'(i[20]) * 2048 + longint'(i[30:21]) * 2;
                w = 21;
            end
            int'(IMM_ZTYPE): v = longint'(i[19:15]);
            default:         e.ill = 1;
        endcase
        if (w > 0 && v >= (longint'(1) << (w - 1))) v = v - (longint'(1) << w);
        e.imm = (xlen == 32) ? {32'b0, 32'(v)} : 64'(v);
        e.tgt = pc + e.imm;
        if (xlen == 32) e.tgt[63:32] = '0;
        return e;
    endfunction

    task automatic idle();
        bus.I_flush    = 0; bus.I_valid   = 0; bus.I_ready   = 0;
        bus.I_immsel   = '0; bus.I_data   = '0;
        bus64.I_flush  = 0; bus64.I_valid = 0; bus64.I_ready = 0;
        bus64.I_immsel = '0; bus64.I_data = '0;
`ifdef IMM_TARGET_EN
        bus.I_pc = '0; bus64.I_pc = '0;
`endif
    endtask

    task automatic test_reset();
        idle();
        #1 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        n_cmp++;
        if (bus.O_valid !== 1'b0 || bus.O_ready !== 1'b1 || bus.O_data !== '0 || bus.O_illegal !== 1'b0) begin
            n_fail++;
            $display("FAIL reset32: got v=%b r=%b d=%h il=%b want v=0 r=1 d=0 il=0",
                     bus.O_valid, bus.O_ready, bus.O_data, bus.O_illegal);
        end
        n_cmp++;
        if (bus64.O_valid !== 1'b0 || bus64.O_ready !== 1'b1 || bus64.O_data !== '0) begin
            n_fail++;
            $display("FAIL reset64: got v=%b r=%b d=%h want v=0 r=1 d=0",
                     bus64.O_valid, bus64.O_ready, bus64.O_data);
        end
`ifdef IMM_TARGET_EN
        n_cmp++;
        if (bus.O_target !== '0) begin
            n_fail++;
            $display("FAIL reset_target: got %h want 0", bus.O_target);
        end
`endif
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_formats();
        logic [2:0]  sels [6];
        logic [31:0] exps [6];
        sels = '{IMM_ITYPE, IMM_STYPE, IMM_BTYPE, IMM_UTYPE, IMM_JTYPE, IMM_ZTYPE};
        exps = '{32'd2, 32'd8, 32'd8, 32'h0020_8000, 32'h0000_8002, 32'd1};
        idle();
        bus.I_ready = 1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            bus.I_valid  = 1;
            bus.I_immsel = sels[k];
            bus.I_data   = 32'h0020_8463;
            @(negedge clk);
            bus.I_valid = 0;
            n_cmp++;
            if (bus.O_valid !== 1'b1 || bus.O_data !== exps[k] || bus.O_illegal !== 1'b0) begin
                n_fail++;
                $display("FAIL format_sel%0d: got v=%b d=%h il=%b want v=1 d=%h il=0",
                         k, bus.O_valid, bus.O_data, bus.O_illegal, exps[k]);
            end
        end
        @(negedge clk);
    endtask

    task automatic test_xlen64();
        logic [2:0]  sels [3];
        logic [31:0] insts [3];
        logic [63:0] exps [3];
        bit          ills [3];
        sels  = '{IMM_ITYPE, IMM_ZTYPE, 3'b111};
        insts = '{32'hFFF0_0093, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        exps  = '{64'hFFFF_FFFF_FFFF_FFFF, 64'h1F, 64'h0};
        ills  = '{1'b0, 1'b0, 1'b1};
        idle();
        bus64.I_ready = 1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            bus64.I_valid  = 1;
            bus64.I_immsel = sels[k];
            bus64.I_data   = insts[k];
            @(negedge clk);
            bus64.I_valid = 0;
            n_cmp++;
            if (bus64.O_valid !== 1'b1 || bus64.O_data !== exps[k] || bus64.O_illegal !== ills[k]) begin
                n_fail++;
                $display("FAIL xlen64_case%0d: got v=%b d=%h il=%b want v=1 d=%h il=%b",
                         k, bus64.O_valid, bus64.O_data, bus64.O_illegal, exps[k], ills[k]);
            end
        end
        @(negedge clk);
    endtask

    task automatic test_backpressure();
        int          accepted = 0;
        int          got = 0;
        logic [31:0] inst;
        exp_t        e;
        idle();
        sb.delete();
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            inst         = {12'(k + 1), 20'h00093};
            bus.I_valid  = 1;
            bus.I_immsel = IMM_ITYPE;
            bus.I_data   = inst;
            if (bus.O_ready) begin
                accepted++;
                sb.push_back(ref_model(int'(IMM_ITYPE), inst, 64'h0, 32));
            end
        end
        @(negedge clk);
        bus.I_valid = 0;
        n_cmp++;
        if (accepted != 2 || bus.O_ready !== 1'b0 || bus.O_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_fill: got acc=%0d r=%b v=%b want acc=2 r=0 v=1",
                     accepted, bus.O_ready, bus.O_valid);
        end
        repeat (2) @(negedge clk);
        n_cmp++;
        if (bus.O_data !== 32'd1) begin
            n_fail++;
            $display("FAIL bp_hold: got d=%h want 00000001", bus.O_data);
        end
        bus.I_ready = 1;
        for (int c = 0; c < 5; c++) begin
            if (bus.O_valid) begin
                got++;
                n_cmp++;
                if (sb.size() == 0) begin
                    n_fail++;
                    $display("FAIL bp_dup: got extra d=%h want none", bus.O_data);
                end else begin
                    e = sb.pop_front();
                    if (bus.O_data !== e.imm[31:0]) begin
                        n_fail++;
                        $display("FAIL bp_order: got d=%h want %h", bus.O_data, e.imm[31:0]);
                    end
                end
            end
            @(negedge clk);
        end
        n_cmp++;
        if (got != 2 || bus.O_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_drain: got beats=%0d r=%b want beats=2 r=1", got, bus.O_ready);
        end
        idle();
    endtask

    task automatic test_random_stream();
        int          acc_n = 0, cyc = 0, phase = 0, ph1_start = 0, beats = 0;
        bit          hold_pend = 0;
        logic [31:0] h_data, inst;
        logic        h_ill;
        logic [63:0] pc;
        exp_t        e;
        idle();
        sb.delete();
        while (cyc < 4000) begin
            @(negedge clk);
            cyc++;
            if (phase == 0 && acc_n >= 100) begin phase = 1; ph1_start = cyc; end
            if (phase == 1 && cyc - ph1_start >= 30) phase = 2;
            if (phase == 2 && sb.size() == 0) break;
            inst         = $urandom;
            pc           = {32'b0, 32'($urandom)};
            bus.I_data   = inst;
            bus.I_immsel = 3'($urandom_range(0, 7));
`ifdef IMM_TARGET_EN
            bus.I_pc     = pc[31:0];
`endif
            bus.I_valid  = (phase == 0) ? ($urandom_range(0, 3) != 0) : (phase == 1);
            bus.I_ready  = (phase == 0) ? ($urandom_range(0, 2) != 0) : 1'b1;

            n_cmp++;
            if (bus.O_valid !== (sb.size() != 0) || bus.O_ready !== (sb.size() < 2)) begin
                n_fail++;
                $display("FAIL rand_occ: got v=%b r=%b want v=%b r=%b (held %0d)",
                         bus.O_valid, bus.O_ready, sb.size() != 0, sb.size() < 2, sb.size());
            end
            if (hold_pend) begin
                n_cmp++;
                if (bus.O_valid !== 1'b1 || bus.O_data !== h_data || bus.O_illegal !== h_ill) begin
                    n_fail++;
                    $display("FAIL rand_stable: got v=%b d=%h il=%b want v=1 d=%h il=%b",
                             bus.O_valid, bus.O_data, bus.O_illegal, h_data, h_ill);
                end
            end
            hold_pend = bus.O_valid && !bus.I_ready;
            h_data    = bus.O_data;
            h_ill     = bus.O_illegal;

            if (bus.O_valid && bus.I_ready) begin
                n_cmp++;
                if (phase == 1 && cyc - ph1_start >= 2) beats++;
                if (sb.size() == 0) begin
                    n_fail++;
                    $display("FAIL rand_extra: got d=%h want no beat", bus.O_data);
                end else begin
                    e = sb.pop_front();
                    if (bus.O_data !== e.imm[31:0] || bus.O_illegal !== e.ill) begin
                        n_fail++;
                        $display("FAIL rand_data: got d=%h il=%b want d=%h il=%b",
                                 bus.O_data, bus.O_illegal, e.imm[31:0], e.ill);
                    end
`ifdef IMM_TARGET_EN
                    if (bus.O_target !== e.tgt[31:0]) begin
                        n_fail++;
                        $display("FAIL rand_target: got %h want %h", bus.O_target, e.tgt[31:0]);
                    end
`endif
                end
            end
            if (bus.I_valid && bus.O_ready) begin
                sb.push_back(ref_model(int'(bus.I_immsel), inst, pc, 32));
                acc_n++;
            end
        end
        n_cmp++;
        if (acc_n < 100 || sb.size() != 0) begin
            n_fail++;
            $display("FAIL rand_timeout: got acc=%0d left=%0d want acc>=100 left=0", acc_n, sb.size());
        end
        n_cmp++;
        if (beats != 28) begin
            n_fail++;
            $display("FAIL rand_throughput: got %0d beats want 28", beats);
        end
        idle();
    endtask

    task automatic test_flush();
        idle();
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            bus.I_valid  = 1;
            bus.I_immsel = IMM_ITYPE;
            bus.I_data   = {12'(k + 5), 20'h00093};
        end
        @(negedge clk);
        n_cmp++;
        if (bus.O_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_pre: got r=%b want r=0", bus.O_ready);
        end
        bus.I_flush = 1;
        bus.I_data  = 32'h7770_0093;
        @(negedge clk);
        bus.I_flush = 0;
        bus.I_valid = 0;
        n_cmp++;
        if (bus.O_valid !== 1'b0 || bus.O_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL flush_post: got v=%b r=%b want v=0 r=1", bus.O_valid, bus.O_ready);
        end
        bus.I_ready = 1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            n_cmp++;
            if (bus.O_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL flush_leak: got v=1 d=%h want v=0", bus.O_data);
            end
        end
        idle();
    endtask

    task automatic test_reset_midstream();
        idle();
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            bus.I_valid  = 1;
            bus.I_immsel = IMM_UTYPE;
            bus.I_data   = 32'hABCD_E037 + 32'(k);
        end
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        n_cmp++;
        if (bus.O_valid !== 1'b0 || bus.O_ready !== 1'b1 || bus.O_data !== '0 || bus.O_illegal !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid: got v=%b r=%b d=%h il=%b want v=0 r=1 d=0 il=0",
                     bus.O_valid, bus.O_ready, bus.O_data, bus.O_illegal);
        end
        @(negedge clk);
        bus.I_valid = 0;
        bus.I_ready = 1;
        rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            n_cmp++;
            if (bus.O_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_leak: got v=1 d=%h want v=0", bus.O_data);
            end
        end
        idle();
    endtask

`ifdef IMM_TARGET_EN
    task automatic test_target();
        idle();
        bus.I_ready = 1;
        @(negedge clk);
        bus.I_valid  = 1;
        bus.I_immsel = IMM_BTYPE;
        bus.I_data   = 32'h0020_8463;
        bus.I_pc     = 32'hFFFF_FFF8;
        @(negedge clk);
        bus.I_valid = 0;
        n_cmp++;
        if (bus.O_valid !== 1'b1 || bus.O_data !== 32'd8 || bus.O_target !== 32'h0) begin
            n_fail++;
            $display("FAIL target_wrap: got v=%b d=%h t=%h want v=1 d=00000008 t=00000000",
                     bus.O_valid, bus.O_data, bus.O_target);
        end
        idle();
    endtask
`endif

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_formats();
        test_xlen64();
        test_backpressure();
        test_random_stream();
        test_flush();
        test_reset_midstream();
`ifdef IMM_TARGET_EN
        test_target();
`endif
        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
